// File: rtl/nor_flash_pkg.sv
// Shared types and constants for the APB parallel NOR flash reader.
// Used by apb_nor_flash_ctrl and nor_flash_beat_seq.
package nor_flash_pkg;

    localparam int WAIT_W = 8;

    // Only register-window offset that is implemented.
    localparam logic [31:0] TIMING_OFS = 32'h0000_0000;

    typedef struct packed {
        logic [WAIT_W-1:0] page;
        logic [WAIT_W-1:0] first;
    } timing_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BEAT = 2'd1,
        ST_DONE = 2'd2
    } fsm_state_e;

endpackage

// File: rtl/nor_flash_beat_seq.sv
// Flash beat sequencer: FSM, beat and wait counters, page-crossing compare
// and the registered flash address / chip-enable / output-enable pins.
module nor_flash_beat_seq
    import nor_flash_pkg::*;
#(
    parameter int FLASH_DW   = 16,
    parameter int APB_DW     = 32,
    parameter int FLASH_AW   = 27,
    parameter int PAGE_BYTES = 16,
    localparam int BEAT_W    = $clog2(APB_DW / FLASH_DW)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                start_i,
    input  logic [FLASH_AW-1:0] base_addr_i,
    input  logic [WAIT_W-1:0]   first_wait_i,
    input  logic [WAIT_W-1:0]   page_wait_i,
    output logic                idle_o,
    output logic                done_o,
    output logic                sample_o,
    output logic [BEAT_W-1:0]   beat_o,
    output logic [FLASH_AW-1:0] flash_a_o,
    output logic                flash_ce_b_o,
    output logic                flash_oe_b_o
);

    localparam int BEATS   = APB_DW / FLASH_DW;
    localparam int PAGE_SH = $clog2(PAGE_BYTES);

    fsm_state_e          state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [FLASH_AW-1:0] addr_q, addr_d;
    logic                ce_b_q, ce_b_d;
    logic [FLASH_AW-1:0] next_addr;
    logic                last_beat;
    logic                same_page;

    // Beats are consecutive flash words, so the next beat is one word further on.
    assign next_addr = addr_q + FLASH_AW'(FLASH_DW / 8);
    assign same_page = (addr_q >> PAGE_SH) == (next_addr >> PAGE_SH);
    assign last_beat = (beat_q == BEAT_W'(BEATS - 1));

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        wait_d   = wait_q;
        addr_d   = addr_q;
        ce_b_d   = ce_b_q;
        sample_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_BEAT;
                    beat_d  = '0;
                    wait_d  = first_wait_i;
                    addr_d  = base_addr_i;
                    ce_b_d  = 1'b0;
                end
            end
            ST_BEAT: begin
                if (wait_q == '0) begin
                    sample_o = 1'b1;
                    if (last_beat) begin
                        state_d = ST_DONE;
                        ce_b_d  = 1'b1;
                    end else begin
                        beat_d = beat_q + 1'b1;
                        addr_d = next_addr;
                        wait_d = same_page ? page_wait_i : first_wait_i;
                    end
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            wait_q  <= '0;
            addr_q  <= '0;
            ce_b_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            wait_q  <= wait_d;
            addr_q  <= addr_d;
            ce_b_q  <= ce_b_d;
        end
    end

    assign idle_o       = (state_q == ST_IDLE);
    assign done_o       = (state_q == ST_DONE);
    assign beat_o       = beat_q;
    assign flash_a_o    = addr_q;
    assign flash_ce_b_o = ce_b_q;
    assign flash_oe_b_o = ce_b_q;

endmodule

// File: rtl/apb_nor_flash_ctrl.sv
// APB slave reading asynchronous parallel NOR flash with programmable waits.
// Optional one-word read line buffer enabled by defining NOR_FLASH_LINEBUF_EN.
module apb_nor_flash_ctrl
    import nor_flash_pkg::*;
#(
    parameter int         FLASH_DW   = 16,
    parameter int         APB_DW     = 32,
    parameter int         FLASH_AW   = 27,
    parameter int         PAGE_BYTES = 16,
    parameter logic [7:0] FIRST_WAIT = 8'd200,
    parameter logic [7:0] PAGE_WAIT  = 8'd40
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                psel,
    input  logic                penable,
    input  logic                pwrite,
    input  logic [31:0]         paddr,
    input  logic [APB_DW-1:0]   pwdata,
    output logic [APB_DW-1:0]   prdata,
    output logic                pready,
    output logic                pslverr,
    input  logic [FLASH_DW-1:0] flash_dq_i,
    output logic [FLASH_DW-1:0] flash_dq_o,
    output logic [FLASH_DW-1:0] flash_dq_t,
    output logic [FLASH_AW-1:0] flash_a,
    output logic                flash_ce_b,
    output logic                flash_oe_b,
    output logic                flash_we_b,
    output logic                flash_adv_b,
    input  logic                flash_wait
);

    localparam int BEAT_W   = $clog2(APB_DW / FLASH_DW);
    localparam int LINE_LSB = $clog2(APB_DW / 8);

    timing_t             timing_q, timing_d;
    logic [APB_DW-1:0]   prdata_q, prdata_d;
    logic                seq_idle, seq_done, seq_sample;
    logic [BEAT_W-1:0]   seq_beat;
    logic                access, reg_acc, data_wr, rd_start, ofs_ok, timing_wr;
    logic                lb_hit;
    logic [FLASH_AW-1:0] base_addr;
    logic                unused_inputs;

    // New accesses are only accepted while the sequencer is idle.
    assign access    = rstn & psel & penable & seq_idle;
    assign reg_acc   = access & paddr[FLASH_AW];
    assign data_wr   = access & ~paddr[FLASH_AW] & pwrite;
    assign rd_start  = access & ~paddr[FLASH_AW] & ~pwrite & ~lb_hit;
    assign ofs_ok    = (paddr[FLASH_AW-1:0] == FLASH_AW'(TIMING_OFS));
    assign timing_wr = reg_acc & pwrite & ofs_ok;
    assign base_addr = {paddr[FLASH_AW-1:LINE_LSB], {LINE_LSB{1'b0}}};

`ifdef NOR_FLASH_LINEBUF_EN
    logic [FLASH_AW-LINE_LSB-1:0] lb_tag_q;
    logic                         lb_valid_q;

    // The buffered word itself is prdata_q: it always holds the last completed read.
    assign lb_hit = lb_valid_q & (lb_tag_q == paddr[FLASH_AW-1:LINE_LSB])
                  & access & ~paddr[FLASH_AW] & ~pwrite;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            lb_valid_q <= 1'b0;
            lb_tag_q   <= '0;
        end else if (timing_wr || rd_start) begin
            lb_valid_q <= 1'b0;
        end else if (seq_done) begin
            lb_valid_q <= 1'b1;
            lb_tag_q   <= paddr[FLASH_AW-1:LINE_LSB];
        end
    end
`else
    assign lb_hit = 1'b0;
`endif

    nor_flash_beat_seq #(
        .FLASH_DW   (FLASH_DW),
        .APB_DW     (APB_DW),
        .FLASH_AW   (FLASH_AW),
        .PAGE_BYTES (PAGE_BYTES)
    ) u_seq (
        .clk          (clk),
        .rstn         (rstn),
        .start_i      (rd_start),
        .base_addr_i  (base_addr),
        .first_wait_i (timing_q.first),
        .page_wait_i  (timing_q.page),
        .idle_o       (seq_idle),
        .done_o       (seq_done),
        .sample_o     (seq_sample),
        .beat_o       (seq_beat),
        .flash_a_o    (flash_a),
        .flash_ce_b_o (flash_ce_b),
        .flash_oe_b_o (flash_oe_b)
    );

    always_comb begin
        timing_d = timing_q;
        if (timing_wr) timing_d = timing_t'(pwdata[15:0]);
    end

    always_comb begin
        prdata_d = prdata_q;
        if (seq_sample) prdata_d[seq_beat*FLASH_DW +: FLASH_DW] = flash_dq_i;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            timing_q <= '{page: PAGE_WAIT, first: FIRST_WAIT};
            prdata_q <= '0;
        end else begin
            timing_q <= timing_d;
            prdata_q <= prdata_d;
        end
    end

    always_comb begin
        prdata = prdata_q;
        if (reg_acc && !pwrite) prdata = ofs_ok ? APB_DW'(timing_q) : '0;
    end

    assign pready  = seq_done | data_wr | reg_acc | lb_hit;
    assign pslverr = data_wr | (reg_acc & ~ofs_ok);

    // The data bus is never driven: reads only, in asynchronous mode.
    assign flash_dq_o  = '0;
    assign flash_dq_t  = '1;
    assign flash_we_b  = 1'b1;
    assign flash_adv_b = 1'b0;

    assign unused_inputs = ^{flash_wait, pwdata, paddr};

endmodule
